// File: rtl/singlecycle_pkg.sv
// Shared constants and types for the RV32I single-cycle PC / branch stage.
// Holds the branch funct3 codes, the reset and trap vectors, and the PC FSM state type.
package singlecycle_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_TRAP = 1'b1
    } pc_state_e;

    // JALR drops bit 0 of the computed address before it becomes the PC.
    function automatic logic [31:0] jalr_target(input logic [31:0] base, input logic [31:0] imm);
        return (base + imm) & ~32'h1;
    endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// Control-flow bus between decode/comparator and the PC / branch stage.
// slave = the PC unit, master = whoever drives decode fields and observes the PC.
interface pc_branch_unit_if;
    import singlecycle_pkg::*;

    logic        i_stall;
    logic        i_is_br;
    logic        i_is_jal;
    logic        i_is_jalr;
    logic [2:0]  i_br_funct3;
    logic        i_br_eq;
    logic        i_br_lt;
    logic [31:0] i_imm;
    logic [31:0] i_rs1_data;
    logic        i_trap_clr;

    logic        o_br_un;
    logic [31:0] o_pc;
    logic [31:0] o_pc_four;
    logic        o_taken;
    logic        o_misalign;
    logic [31:0] o_bad_addr;
    logic [31:0] o_br_cnt;
    logic [31:0] o_br_taken_cnt;

    modport slave (
        input  i_stall, i_is_br, i_is_jal, i_is_jalr, i_br_funct3,
               i_br_eq, i_br_lt, i_imm, i_rs1_data, i_trap_clr,
        output o_br_un, o_pc, o_pc_four, o_taken, o_misalign,
               o_bad_addr, o_br_cnt, o_br_taken_cnt
    );

    modport master (
        output i_stall, i_is_br, i_is_jal, i_is_jalr, i_br_funct3,
               i_br_eq, i_br_lt, i_imm, i_rs1_data, i_trap_clr,
        input  o_br_un, o_pc, o_pc_four, o_taken, o_misalign,
               o_bad_addr, o_br_cnt, o_br_taken_cnt
    );

endinterface

// File: rtl/pc_branch_unit_br_decide.sv
// Conditional-branch decision: maps funct3 plus comparator flags to taken,
// and tells the comparator whether to compare unsigned.
module br_decide
    import singlecycle_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       eq,
    input  logic       lt,
    output logic       taken,
    output logic       br_un
);

    // BLTU/BGEU are the only codes with bit 1 set among valid branches.
    assign br_un = funct3[1];

    always_comb begin
        taken = 1'b0;
        case (funct3)
            BR_BEQ:           taken = eq;
            BR_BNE:           taken = ~eq;
            BR_BLT, BR_BLTU:  taken = lt;
            BR_BGE, BR_BGEU:  taken = ~lt;
            default:          taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_branch_unit.sv
// PC register, branch/JAL/JALR resolution and misaligned-target trap FSM.
// Optional branch counters are built when PC_BRANCH_PERF_CNT_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------------------
// PC_RUN  | normal fetch; PC advances by 4 or to a redirect target
// PC_TRAP | misaligned target seen; PC parked at TRAP_VEC until i_trap_clr
module pc_branch_unit
    import singlecycle_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    pc_branch_unit_if.slave    bus
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] bad_addr_q, bad_addr_d;

    logic        dec_taken;
    logic        br_taken;
    logic        redirect;
    logic        taken;
    logic [31:0] pc_four;
    logic [31:0] target;
    logic        target_bad;
    logic        advance;

    br_decide u_br_decide (
        .funct3 (bus.i_br_funct3),
        .eq     (bus.i_br_eq),
        .lt     (bus.i_br_lt),
        .taken  (dec_taken),
        .br_un  (bus.o_br_un)
    );

    assign pc_four    = pc_q + 32'd4;
    assign br_taken   = bus.i_is_br & dec_taken;
    assign redirect   = bus.i_is_jalr | bus.i_is_jal | br_taken;
    assign target     = bus.i_is_jalr ? jalr_target(bus.i_rs1_data, bus.i_imm)
                                      : (pc_q + bus.i_imm);
    assign taken      = (state_q == PC_RUN) & redirect;
    assign target_bad = taken & target[1];
    assign advance    = (state_q == PC_RUN) & ~bus.i_stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        bad_addr_d = bad_addr_q;
        case (state_q)
            PC_RUN: begin
                if (!bus.i_stall) begin
                    if (target_bad) begin
                        state_d    = PC_TRAP;
                        pc_d       = TRAP_VEC;
                        misalign_d = 1'b1;
                        bad_addr_d = target;
                    end else begin
                        pc_d = taken ? target : pc_four;
                    end
                end
            end
            PC_TRAP: begin
                pc_d = TRAP_VEC;
                if (bus.i_trap_clr) begin
                    state_d    = PC_RUN;
                    misalign_d = 1'b0;
                end
            end
            default: begin
                state_d = PC_RUN;
                pc_d    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= PC_RUN;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            bad_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
        end
    end

`ifdef PC_BRANCH_PERF_CNT_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] br_taken_cnt_q, br_taken_cnt_d;

    // A branch that traps still counts as executed and taken.
    always_comb begin
        br_cnt_d       = br_cnt_q;
        br_taken_cnt_d = br_taken_cnt_q;
        if (advance && bus.i_is_br) begin
            br_cnt_d = br_cnt_q + 32'd1;
            if (dec_taken) begin
                br_taken_cnt_d = br_taken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            br_cnt_q       <= 32'h0;
            br_taken_cnt_q <= 32'h0;
        end else begin
            br_cnt_q       <= br_cnt_d;
            br_taken_cnt_q <= br_taken_cnt_d;
        end
    end

    assign bus.o_br_cnt       = br_cnt_q;
    assign bus.o_br_taken_cnt = br_taken_cnt_q;
`else
    logic unused_advance;
    assign unused_advance     = advance;
    assign bus.o_br_cnt       = 32'h0;
    assign bus.o_br_taken_cnt = 32'h0;
`endif

    assign bus.o_pc       = pc_q;
    assign bus.o_pc_four  = pc_four;
    assign bus.o_taken    = taken;
    assign bus.o_misalign = misalign_q;
    assign bus.o_bad_addr = bad_addr_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: table of single-cycle vectors plus
// hand sequences for trap entry/exit, stall and asynchronous reset.
module tb_pc_branch_unit;
    import singlecycle_pkg::*;

`ifdef PC_BRANCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pc_branch_unit_if bus ();

    pc_branch_unit dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_br;
        logic        is_jal;
        logic        is_jalr;
        logic [2:0]  funct3;
        logic        eq;
        logic        lt;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        exp_br_un;
        logic        exp_taken;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_stall     = 1'b0;
        bus.i_is_br     = 1'b0;
        bus.i_is_jal    = 1'b0;
        bus.i_is_jalr   = 1'b0;
        bus.i_br_funct3 = 3'b000;
        bus.i_br_eq     = 1'b0;
        bus.i_br_lt     = 1'b0;
        bus.i_imm       = 32'h0;
        bus.i_rs1_data  = 32'h0;
        bus.i_trap_clr  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},       bus.o_pc,           RESET_PC);
        chk({tag, "_pc_four"},  bus.o_pc_four,      RESET_PC + 32'd4);
        chk({tag, "_misalign"}, {31'h0, bus.o_misalign}, 32'h0);
        chk({tag, "_bad_addr"}, bus.o_bad_addr,     32'h0);
        chk({tag, "_br_cnt"},   bus.o_br_cnt,       32'h0);
        chk({tag, "_tk_cnt"},   bus.o_br_taken_cnt, 32'h0);
    endtask

    initial begin
        logic [31:0] cur_pc;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();

        //          br  jal jalr f3      eq  lt  imm            rs1           un  tk  next pc
        vecs[0]  = '{1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0,       1'b0,1'b0,32'h0000_0004};
        vecs[1]  = '{1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0,       1'b0,1'b0,32'h0000_0008};
        vecs[2]  = '{1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0,       1'b0,1'b0,32'h0000_000C};
        vecs[3]  = '{1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0,       1'b0,1'b0,32'h0000_0010};
        vecs[4]  = '{1'b1,1'b0,1'b0,3'b100,1'b0,1'b1,32'h20,       32'h0,       1'b0,1'b1,32'h0000_0030};
        vecs[5]  = '{1'b0,1'b1,1'b0,3'b000,1'b0,1'b0,32'h10,       32'h0,       1'b0,1'b1,32'h0000_0040};
        vecs[6]  = '{1'b1,1'b0,1'b0,3'b111,1'b0,1'b1,32'h40,       32'h0,       1'b1,1'b0,32'h0000_0044};
        vecs[7]  = '{1'b1,1'b0,1'b0,3'b010,1'b1,1'b1,32'h40,       32'h0,       1'b1,1'b0,32'h0000_0048};
        vecs[8]  = '{1'b1,1'b0,1'b0,3'b001,1'b1,1'b0,32'h40,       32'h0,       1'b0,1'b0,32'h0000_004C};
        vecs[9]  = '{1'b1,1'b0,1'b0,3'b001,1'b0,1'b0,32'hFFFF_FFF4,32'h0,       1'b0,1'b1,32'h0000_0040};
        vecs[10] = '{1'b1,1'b0,1'b0,3'b101,1'b1,1'b0,32'h8,        32'h0,       1'b0,1'b1,32'h0000_0048};
        vecs[11] = '{1'b1,1'b0,1'b0,3'b110,1'b0,1'b0,32'h8,        32'h0,       1'b1,1'b0,32'h0000_004C};
        vecs[12] = '{1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,32'h1,        32'h200,     1'b0,1'b1,32'h0000_0200};
        vecs[13] = '{1'b0,1'b1,1'b1,3'b000,1'b0,1'b0,32'h4,        32'h300,     1'b0,1'b1,32'h0000_0304};
        vecs[14] = '{1'b0,1'b1,1'b0,3'b000,1'b0,1'b0,32'h10,       32'h0,       1'b0,1'b1,32'h0000_0314};
        vecs[15] = '{1'b0,1'b1,1'b0,3'b000,1'b0,1'b0,32'hFFFF_FCE8,32'h0,       1'b0,1'b1,32'hFFFF_FFFC};
        vecs[16] = '{1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0,       1'b0,1'b0,32'h0000_0000};

        tick();
        tick();
        chk_reset_state("rst_hold");
        rst_n = 1'b1;
        #1;
        chk_reset_state("rst_rel");

        // Table: each vector is one RUN cycle.
        cur_pc = RESET_PC;
        for (int i = 0; i < 17; i++) begin
            idle_inputs();
            bus.i_is_br     = vecs[i].is_br;
            bus.i_is_jal    = vecs[i].is_jal;
            bus.i_is_jalr   = vecs[i].is_jalr;
            bus.i_br_funct3 = vecs[i].funct3;
            bus.i_br_eq     = vecs[i].eq;
            bus.i_br_lt     = vecs[i].lt;
            bus.i_imm       = vecs[i].imm;
            bus.i_rs1_data  = vecs[i].rs1;
            #1;
            chk($sformatf("v%0d_br_un", i), {31'h0, bus.o_br_un}, {31'h0, vecs[i].exp_br_un});
            chk($sformatf("v%0d_taken", i), {31'h0, bus.o_taken}, {31'h0, vecs[i].exp_taken});
            chk($sformatf("v%0d_pc_four", i), bus.o_pc_four, cur_pc + 32'd4);
            tick();
            chk($sformatf("v%0d_pc", i), bus.o_pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_misalign", i), {31'h0, bus.o_misalign}, 32'h0);
            cur_pc = vecs[i].exp_pc;
        end
        chk("tbl_br_cnt", bus.o_br_cnt,       PERF ? 32'd7 : 32'd0);
        chk("tbl_tk_cnt", bus.o_br_taken_cnt, PERF ? 32'd3 : 32'd0);

        // Misaligned JALR from PC 0 enters TRAP.
        idle_inputs();
        bus.i_is_jalr  = 1'b1;
        bus.i_rs1_data = 32'h1003;
        #1;
        chk("mis_taken", {31'h0, bus.o_taken}, 32'h1);
        tick();
        chk("mis_pc",       bus.o_pc,       TRAP_VEC);
        chk("mis_flag",     {31'h0, bus.o_misalign}, 32'h1);
        chk("mis_bad_addr", bus.o_bad_addr, 32'h1002);

        // Parked for three cycles despite redirect requests and a stall.
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            bus.i_is_jal = 1'b1;
            bus.i_imm    = 32'h8;
            bus.i_stall  = (k == 1);
            #1;
            chk($sformatf("trap%0d_taken", k), {31'h0, bus.o_taken}, 32'h0);
            tick();
            chk($sformatf("trap%0d_pc", k),   bus.o_pc, TRAP_VEC);
            chk($sformatf("trap%0d_flag", k), {31'h0, bus.o_misalign}, 32'h1);
        end

        // Clear wins over stall in TRAP.
        idle_inputs();
        bus.i_trap_clr = 1'b1;
        bus.i_stall    = 1'b1;
        tick();
        chk("clr_pc",       bus.o_pc,       TRAP_VEC);
        chk("clr_flag",     {31'h0, bus.o_misalign}, 32'h0);
        chk("clr_bad_addr", bus.o_bad_addr, 32'h1002);
        idle_inputs();
        tick();
        chk("resume_pc", bus.o_pc, TRAP_VEC + 32'd4);

        // Fresh reset, then a taken BEQ held off by two stall cycles.
        rst_n = 1'b0;
        #1;
        chk_reset_state("rst2");
        rst_n = 1'b1;
        idle_inputs();
        bus.i_is_br     = 1'b1;
        bus.i_br_funct3 = BR_BEQ;
        bus.i_br_eq     = 1'b1;
        bus.i_imm       = 32'h8;
        bus.i_stall     = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("stall%0d_taken", k), {31'h0, bus.o_taken}, 32'h1);
            tick();
            chk($sformatf("stall%0d_pc", k),     bus.o_pc,           32'h0);
            chk($sformatf("stall%0d_br_cnt", k), bus.o_br_cnt,       32'h0);
            chk($sformatf("stall%0d_tk_cnt", k), bus.o_br_taken_cnt, 32'h0);
        end
        bus.i_stall = 1'b0;
        tick();
        chk("unstall_pc",     bus.o_pc,           32'h8);
        chk("unstall_br_cnt", bus.o_br_cnt,       PERF ? 32'd1 : 32'd0);
        chk("unstall_tk_cnt", bus.o_br_taken_cnt, PERF ? 32'd1 : 32'd0);

        // A taken branch to a misaligned target traps and still counts.
        idle_inputs();
        bus.i_is_br     = 1'b1;
        bus.i_br_funct3 = BR_BNE;
        bus.i_br_eq     = 1'b0;
        bus.i_imm       = 32'h2;
        tick();
        chk("brtrap_pc",     bus.o_pc,       TRAP_VEC);
        chk("brtrap_flag",   {31'h0, bus.o_misalign}, 32'h1);
        chk("brtrap_bad",    bus.o_bad_addr, 32'h0000_000A);
        chk("brtrap_br_cnt", bus.o_br_cnt,       PERF ? 32'd2 : 32'd0);
        chk("brtrap_tk_cnt", bus.o_br_taken_cnt, PERF ? 32'd2 : 32'd0);

        // Asynchronous reset between edges while in TRAP.
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("rst_trap");
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_pc",   bus.o_pc, 32'h4);
        chk("post_rst_flag", {31'h0, bus.o_misalign}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
